dr32e_dec_mon: RTL and testbench

- Synthesizable decode-stage monitor/checker for the dr32e core. Sits beside the decoder and observes its control outputs every cycle a decoded instruction is valid.
- Checks a parametrised set of consistency rules and records the first violation in a capture register.
- Pushes every violation into a trace FIFO that firmware or the bench drains.
- Optionally keeps per-class saturating event counters.
- Successor to the passive decode monitor: adds an RV32E register-range check, configurable depth and counter width, and a halt-on-error mode.

---
 rtl/dr32e_pkg.sv | 24 ++
 rtl/dr32e_dec_mon_fifo.sv | 52 +++++
 rtl/dr32e_dec_mon.sv | 163 ++++++++++++++++
 tb/tb_dr32e_dec_mon.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dr32e_pkg.sv
// Shared dr32e types for the decode-stage monitor: rule bit positions,
// monitor FSM states and the trace entry width.
package dr32e_pkg;

  typedef enum logic [1:0] {
    MON_MULTI    = 2'd0,
    MON_ILL_SE   = 2'd1,
    MON_ST_NOREQ = 2'd2,
    MON_E_RANGE  = 2'd3
  } dec_mon_code_e;

  typedef enum logic {
    RUN    = 1'b0,
    FROZEN = 1'b1
  } dec_mon_state_e;

  localparam int DecMonTraceW = 36;

  // True when two or more bits are set; clearing the lowest set bit leaves a remainder.
  function automatic logic more_than_one(input logic [5:0] v);
    return (v & (v - 6'd1)) != 6'd0;
  endfunction

endpackage

// File: rtl/dr32e_dec_mon_fifo.sv
// Synchronous FIFO for monitor trace entries; extra pointer MSB tells full from empty,
// and drop_o flags a push that found the FIFO full with no pop to make room.
module dr32e_dec_mon_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A pop on the same edge frees the slot the push is about to reuse.
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && full_o && !do_pop;
  assign data_o  = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) begin
      mem_q[wptr_q[AW-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/dr32e_dec_mon.sv
// Decode-stage consistency monitor: rule checks, first-error capture, trace FIFO, halt mode.
// Event counters are built only when DR32E_DEC_MON_PERF_EN is defined.
module dr32e_dec_mon
  import dr32e_pkg::*;
#(
  parameter bit          RV32E      = 1'b0,
  parameter int unsigned CntWidth   = 16,
  parameter int unsigned TraceDepth = 4,
  parameter bit          HaltOnErr  = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                valid_i,
  input  logic                clr_i,
  input  logic [31:0]         instr_rdata_i,
  input  logic                illegal_insn_i,
  input  logic                rf_we_i,
  input  logic [4:0]          rf_waddr_i,
  input  logic [4:0]          rf_raddr_a_i,
  input  logic [4:0]          rf_raddr_b_i,
  input  logic                rf_ren_a_i,
  input  logic                rf_ren_b_i,
  input  logic                data_req_i,
  input  logic                data_we_i,
  input  logic                mult_en_i,
  input  logic                div_en_i,
  input  logic                csr_access_i,
  input  logic                jump_in_dec_i,
  input  logic                branch_in_dec_i,
  input  logic                branch_taken_i,
  output logic                err_o,
  output logic [3:0]          first_err_code_o,
  output logic [31:0]         first_err_instr_o,
  output logic                trace_valid_o,
  output logic [35:0]         trace_data_o,
  input  logic                trace_rd_i,
  output logic                trace_ovf_o,
  output logic [CntWidth-1:0] cnt_instr_o,
  output logic [CntWidth-1:0] cnt_branch_o,
  output logic [CntWidth-1:0] cnt_taken_o,
  output logic [CntWidth-1:0] cnt_mem_o,
  output logic                frozen_o
);

  dec_mon_state_e state_q;
  logic [3:0]     code;
  logic           viol, run, push, drop, fifo_empty, fifo_full;
  logic           err_q, ovf_q, frozen_q;
  logic [3:0]     first_code_q;
  logic [31:0]    first_instr_q;

  always_comb begin
    code = '0;
    code[MON_MULTI]    = !illegal_insn_i && more_than_one({data_req_i, mult_en_i, div_en_i,
                                                           csr_access_i, jump_in_dec_i,
                                                           branch_in_dec_i});
    code[MON_ILL_SE]   = illegal_insn_i && (rf_we_i || data_req_i);
    code[MON_ST_NOREQ] = data_we_i && !data_req_i;
    code[MON_E_RANGE]  = RV32E && !illegal_insn_i &&
                         ((rf_we_i && rf_waddr_i[4]) || (rf_ren_a_i && rf_raddr_a_i[4]) ||
                          (rf_ren_b_i && rf_raddr_b_i[4]));
  end

  assign viol = valid_i && (code != 4'd0);
  assign run  = (state_q == RUN);
  assign push = viol && run;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= RUN;
      frozen_q      <= 1'b0;
      err_q         <= 1'b0;
      ovf_q         <= 1'b0;
      first_code_q  <= '0;
      first_instr_q <= '0;
    end else if (clr_i) begin
      state_q       <= RUN;
      frozen_q      <= 1'b0;
      err_q         <= 1'b0;
      ovf_q         <= 1'b0;
      first_code_q  <= '0;
      first_instr_q <= '0;
    end else begin
      if (viol) begin
        err_q <= 1'b1;
        if (!err_q) begin
          first_code_q  <= code;
          first_instr_q <= instr_rdata_i;
        end
      end
      if (drop) ovf_q <= 1'b1;
      case (state_q)
        RUN: if (HaltOnErr && viol) begin
          state_q  <= FROZEN;
          frozen_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  dr32e_dec_mon_fifo #(
    .WIDTH(DecMonTraceW),
    .DEPTH(TraceDepth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr_i),
    .push_i (push),
    .pop_i  (trace_rd_i),
    .data_i ({code, instr_rdata_i}),
    .data_o (trace_data_o),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .drop_o (drop)
  );

  assign err_o             = err_q;
  assign first_err_code_o  = first_code_q;
  assign first_err_instr_o = first_instr_q;
  assign trace_valid_o     = !fifo_empty;
  assign trace_ovf_o       = ovf_q;
  assign frozen_o          = frozen_q;

`ifdef DR32E_DEC_MON_PERF_EN
  logic                count_en;
  logic [3:0]          cnt_inc;
  logic [CntWidth-1:0] cnt_all [4];
  logic                unused_full;

  // The instruction that trips the freeze is not counted.
  assign count_en    = valid_i && run && !(HaltOnErr && viol);
  assign cnt_inc     = {data_req_i, branch_in_dec_i && branch_taken_i, branch_in_dec_i, 1'b1};
  assign unused_full = fifo_full;

  for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
    logic [CntWidth-1:0] cnt_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else if (clr_i) begin
        cnt_q <= '0;
      end else if (count_en && cnt_inc[gi] && (cnt_q != {CntWidth{1'b1}})) begin
        cnt_q <= cnt_q + CntWidth'(1);
      end
    end
    assign cnt_all[gi] = cnt_q;
  end

  assign cnt_instr_o  = cnt_all[0];
  assign cnt_branch_o = cnt_all[1];
  assign cnt_taken_o  = cnt_all[2];
  assign cnt_mem_o    = cnt_all[3];
`else
  logic unused_perf;
  assign unused_perf  = branch_taken_i ^ fifo_full;
  assign cnt_instr_o  = '0;
  assign cnt_branch_o = '0;
  assign cnt_taken_o  = '0;
  assign cnt_mem_o    = '0;
`endif

endmodule

// File: tb/tb_dr32e_dec_mon.sv
// Bench for dr32e_dec_mon: two instances (default config and RV32E/halt/CntWidth=2)
// share stimulus and are compared against a queue-based reference model.
module tb_dr32e_dec_mon;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        valid, clr, ill, rf_we, ren_a, ren_b, data_req, data_we;
  logic        mult_en, div_en, csr, jump, branch, taken, trace_rd;
  logic [31:0] instr;
  logic [4:0]  waddr, raddr_a, raddr_b;

  logic        u0_err, u0_tv, u0_ovf, u0_frz;
  logic [3:0]  u0_fcode;
  logic [31:0] u0_finstr;
  logic [35:0] u0_td;
  logic [15:0] u0_ci, u0_cb, u0_ct, u0_cm;
  logic        u1_err, u1_tv, u1_ovf, u1_frz;
  logic [3:0]  u1_fcode;
  logic [31:0] u1_finstr;
  logic [35:0] u1_td;
  logic [1:0]  u1_ci, u1_cb, u1_ct, u1_cm;

  int checks = 0;
  int errors = 0;

  // Reference model state, index 0 = u0, 1 = u1
  bit          m_err [2];
  bit [3:0]    m_code [2];
  bit [31:0]   m_instr [2];
  bit          m_ovf [2];
  bit          m_frozen [2];
  int          m_cnt [2][4];
  logic [35:0] mq0 [$];
  logic [35:0] mq1 [$];

  always #5 clk = ~clk;

  dr32e_dec_mon #(.RV32E(1'b0), .CntWidth(16), .TraceDepth(4), .HaltOnErr(1'b0)) u0 (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid), .clr_i(clr), .instr_rdata_i(instr),
    .illegal_insn_i(ill), .rf_we_i(rf_we), .rf_waddr_i(waddr), .rf_raddr_a_i(raddr_a),
    .rf_raddr_b_i(raddr_b), .rf_ren_a_i(ren_a), .rf_ren_b_i(ren_b), .data_req_i(data_req),
    .data_we_i(data_we), .mult_en_i(mult_en), .div_en_i(div_en), .csr_access_i(csr),
    .jump_in_dec_i(jump), .branch_in_dec_i(branch), .branch_taken_i(taken),
    .err_o(u0_err), .first_err_code_o(u0_fcode), .first_err_instr_o(u0_finstr),
    .trace_valid_o(u0_tv), .trace_data_o(u0_td), .trace_rd_i(trace_rd), .trace_ovf_o(u0_ovf),
    .cnt_instr_o(u0_ci), .cnt_branch_o(u0_cb), .cnt_taken_o(u0_ct), .cnt_mem_o(u0_cm),
    .frozen_o(u0_frz));

  dr32e_dec_mon #(.RV32E(1'b1), .CntWidth(2), .TraceDepth(4), .HaltOnErr(1'b1)) u1 (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid), .clr_i(clr), .instr_rdata_i(instr),
    .illegal_insn_i(ill), .rf_we_i(rf_we), .rf_waddr_i(waddr), .rf_raddr_a_i(raddr_a),
    .rf_raddr_b_i(raddr_b), .rf_ren_a_i(ren_a), .rf_ren_b_i(ren_b), .data_req_i(data_req),
    .data_we_i(data_we), .mult_en_i(mult_en), .div_en_i(div_en), .csr_access_i(csr),
    .jump_in_dec_i(jump), .branch_in_dec_i(branch), .branch_taken_i(taken),
    .err_o(u1_err), .first_err_code_o(u1_fcode), .first_err_instr_o(u1_finstr),
    .trace_valid_o(u1_tv), .trace_data_o(u1_td), .trace_rd_i(trace_rd), .trace_ovf_o(u1_ovf),
    .cnt_instr_o(u1_ci), .cnt_branch_o(u1_cb), .cnt_taken_o(u1_ct), .cnt_mem_o(u1_cm),
    .frozen_o(u1_frz));

  // ---------------- reference model ----------------
  function automatic int q_size(int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [35:0] q_head(int k);
    if (q_size(k) == 0) return 36'd0;
    return (k == 0) ? mq0[0] : mq1[0];
  endfunction

  task automatic q_push(int k, logic [35:0] d);
    if (k == 0) mq0.push_back(d); else mq1.push_back(d);
  endtask

  task automatic q_pop(int k);
    if (k == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_err[k] = 0; m_code[k] = 0; m_instr[k] = 0; m_ovf[k] = 0; m_frozen[k] = 0;
      for (int i = 0; i < 4; i++) m_cnt[k][i] = 0;
    end
    mq0.delete();
    mq1.delete();
  endtask

  function automatic bit [3:0] ref_code(bit rv);
    int units;
    bit [3:0] c;
    units = int'(data_req) + int'(mult_en) + int'(div_en) + int'(csr) + int'(jump) + int'(branch);
    c[0] = !ill && (units > 1);
    c[1] = ill && (rf_we || data_req);
    c[2] = data_we && !data_req;
    c[3] = rv && !ill && ((rf_we && waddr >= 16) || (ren_a && raddr_a >= 16) ||
                          (ren_b && raddr_b >= 16));
    return c;
  endfunction

  task automatic model_step();
    if (clr) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      bit [3:0] c;
      bit v, pop, push;
      int cmax;
      bit inc [4];
      c    = ref_code(k == 1);
      v    = valid && (c != 0);
      pop  = trace_rd && (q_size(k) > 0);
      push = v && !m_frozen[k];
      cmax = (k == 0) ? 65535 : 3;
      if (push && q_size(k) == 4 && !pop) m_ovf[k] = 1;
      else begin
        if (pop) q_pop(k);
        if (push) q_push(k, {c, instr});
      end
      inc[0] = 1; inc[1] = branch; inc[2] = branch && taken; inc[3] = data_req;
      if (valid && !m_frozen[k] && !(k == 1 && v))
        for (int i = 0; i < 4; i++) if (inc[i] && m_cnt[k][i] < cmax) m_cnt[k][i]++;
      if (v && !m_err[k]) begin m_code[k] = c; m_instr[k] = instr; end
      if (v) m_err[k] = 1;
      if (k == 1 && v) m_frozen[k] = 1;
    end
  endtask

  function automatic logic [139:0] pack_exp(int k);
    logic [63:0] cn;
    cn = '0;
`ifdef DR32E_DEC_MON_PERF_EN
    cn = {16'(m_cnt[k][0]), 16'(m_cnt[k][1]), 16'(m_cnt[k][2]), 16'(m_cnt[k][3])};
`endif
    return {m_err[k], m_code[k], m_instr[k], q_size(k) > 0, q_head(k), m_ovf[k], m_frozen[k], cn};
  endfunction

  function automatic logic [139:0] pack_out(int k);
    if (k == 0)
      return {u0_err, u0_fcode, u0_finstr, u0_tv, u0_td, u0_ovf, u0_frz, u0_ci, u0_cb, u0_ct, u0_cm};
    return {u1_err, u1_fcode, u1_finstr, u1_tv, u1_td, u1_ovf, u1_frz,
            14'd0, u1_ci, 14'd0, u1_cb, 14'd0, u1_ct, 14'd0, u1_cm};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_idle();
    valid = 0; clr = 0; ill = 0; rf_we = 0; ren_a = 0; ren_b = 0; data_req = 0; data_we = 0;
    mult_en = 0; div_en = 0; csr = 0; jump = 0; branch = 0; taken = 0; trace_rd = 0;
    instr = 32'd0; waddr = 5'd0; raddr_a = 5'd0; raddr_b = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    $display("txn t=%0t valid=%0b clr=%0b rd=%0b instr=%h u0_err=%0b u1_frz=%0b",
             $time, valid, clr, trace_rd, instr, u0_err, u1_frz);
    #1;
  endtask

  task automatic do_clr();
    set_idle();
    clr = 1;
    tick();
    clr = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_idle();
    rst_ni = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_ni = 1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (pack_out(k) !== pack_exp(k)) begin
        errors++;
        $display("FAIL reset u%0d: got %h want %h", k, pack_out(k), pack_exp(k));
      end
    end
  endtask

  task automatic test_single();
    do_clr();
    valid = 1; mult_en = 1; div_en = 1; instr = 32'h02B50533;
    tick();
    checks++;
    if ({u0_err, u0_fcode, u0_finstr} !== {1'b1, 4'h1, 32'h02B50533}) begin
      errors++;
      $display("FAIL single_first u0: got %b/%h/%h want 1/1/02b50533", u0_err, u0_fcode, u0_finstr);
    end
    checks++;
    if ({u0_tv, u0_td} !== {1'b1, 36'h1_02B50533}) begin
      errors++;
      $display("FAIL single_trace u0: got %b/%h want 1/102b50533", u0_tv, u0_td);
    end
    set_idle();
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (pack_out(k) !== pack_exp(k)) begin
        errors++;
        $display("FAIL single u%0d: got %h want %h", k, pack_out(k), pack_exp(k));
      end
    end
  endtask

  task automatic test_rv32e();
    do_clr();
    valid = 1; rf_we = 1; waddr = 5'd16; instr = 32'h00000833;
    tick();
    set_idle();
    checks++;
    if ({u1_err, u1_fcode} !== {1'b1, 4'h8}) begin
      errors++;
      $display("FAIL rv32e_code u1: got %b/%h want 1/8", u1_err, u1_fcode);
    end
    checks++;
    if (u0_err !== 1'b0) begin
      errors++;
      $display("FAIL rv32e_off u0: got err=%b want 0", u0_err);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (pack_out(k) !== pack_exp(k)) begin
        errors++;
        $display("FAIL rv32e u%0d: got %h want %h", k, pack_out(k), pack_exp(k));
      end
    end
  endtask

  task automatic test_overflow();
    int pops;
    do_clr();
    valid = 1; data_we = 1;
    for (int i = 1; i <= 4; i++) begin
      instr = 32'h100 + 32'(i);
      tick();
    end
    checks++;
    if ({u0_tv, u0_ovf} !== 2'b10) begin
      errors++;
      $display("FAIL ovf_fill u0: got valid/ovf=%b%b want 10", u0_tv, u0_ovf);
    end
    instr = 32'h105; trace_rd = 1;
    tick();
    checks++;
    if ({u0_ovf, u0_td} !== {1'b0, 4'h4, 32'h102}) begin
      errors++;
      $display("FAIL ovf_pushpop u0: got ovf=%b td=%h want 0/400000102", u0_ovf, u0_td);
    end
    instr = 32'h106; trace_rd = 0;
    tick();
    checks++;
    if (u0_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drop u0: got %b want 1", u0_ovf);
    end
    set_idle();
    trace_rd = 1;
    pops = 0;
    for (int n = 0; n < 8 && u0_tv; n++) begin
      pops++;
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (pack_out(k) !== pack_exp(k)) begin
          errors++;
          $display("FAIL ovf_drain u%0d: got %h want %h", k, pack_out(k), pack_exp(k));
        end
      end
    end
    trace_rd = 0;
    checks++;
    if (pops != 4) begin
      errors++;
      $display("FAIL ovf_count u0: got %0d entries want 4", pops);
    end
  endtask

  task automatic test_halt();
    do_clr();
    for (int i = 0; i < 6; i++) begin
      set_idle();
      valid = 1;
      instr = 32'h13 + 32'(i);
      if (i == 3) data_we = 1;
      tick();
    end
    set_idle();
    checks++;
`ifdef DR32E_DEC_MON_PERF_EN
    if ({u1_frz, u1_ci} !== {1'b1, 2'd3}) begin
`else
    if ({u1_frz, u1_ci} !== {1'b1, 2'd0}) begin
`endif
      errors++;
      $display("FAIL halt_freeze u1: got frozen=%b cnt_instr=%0d", u1_frz, u1_ci);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (pack_out(k) !== pack_exp(k)) begin
        errors++;
        $display("FAIL halt u%0d: got %h want %h", k, pack_out(k), pack_exp(k));
      end
    end
    do_clr();
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (pack_out(k) !== 140'd0) begin
        errors++;
        $display("FAIL halt_clr u%0d: got %h want 0", k, pack_out(k));
      end
    end
  endtask

  task automatic test_saturation();
    do_clr();
    valid = 1; branch = 1; taken = 1;
    repeat (5) tick();
    set_idle();
    checks++;
`ifdef DR32E_DEC_MON_PERF_EN
    if ({u1_cb, u1_ct, u0_cb} !== {2'd3, 2'd3, 16'd5}) begin
`else
    if ({u1_cb, u1_ct, u0_cb} !== {2'd0, 2'd0, 16'd0}) begin
`endif
      errors++;
      $display("FAIL saturation: got u1 br=%0d tk=%0d u0 br=%0d", u1_cb, u1_ct, u0_cb);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (pack_out(k) !== pack_exp(k)) begin
        errors++;
        $display("FAIL saturation u%0d: got %h want %h", k, pack_out(k), pack_exp(k));
      end
    end
  endtask

  task automatic test_random();
    do_clr();
    for (int n = 0; n < 400; n++) begin
      valid    = ($urandom_range(3) != 0);
      clr      = ($urandom_range(49) == 0);
      ill      = ($urandom_range(9) == 0);
      rf_we    = $urandom_range(1);
      ren_a    = $urandom_range(1);
      ren_b    = $urandom_range(1);
      waddr    = 5'($urandom_range(31));
      raddr_a  = 5'($urandom_range(31));
      raddr_b  = 5'($urandom_range(31));
      data_req = ($urandom_range(5) == 0);
      data_we  = ($urandom_range(7) == 0);
      mult_en  = ($urandom_range(7) == 0);
      div_en   = ($urandom_range(7) == 0);
      csr      = ($urandom_range(7) == 0);
      jump     = ($urandom_range(7) == 0);
      branch   = ($urandom_range(3) == 0);
      taken    = $urandom_range(1);
      trace_rd = ($urandom_range(2) == 0);
      instr    = $urandom;
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (pack_out(k) !== pack_exp(k)) begin
          errors++;
          $display("FAIL random u%0d n=%0d: got %h want %h", k, n, pack_out(k), pack_exp(k));
        end
      end
    end
    set_idle();
  endtask

  task automatic test_async_reset();
    do_clr();
    valid = 1; data_we = 1; instr = 32'hA1;
    tick();
    instr = 32'hA2;
    tick();
    set_idle();
    checks++;
    if ({u0_err, u0_tv, u0_td} !== {1'b1, 1'b1, 36'h4_000000A1}) begin
      errors++;
      $display("FAIL areset_pre u0: got err=%b tv=%b td=%h", u0_err, u0_tv, u0_td);
    end
    #3 rst_ni = 0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (pack_out(k) !== 140'd0) begin
        errors++;
        $display("FAIL areset u%0d: got %h want 0", k, pack_out(k));
      end
    end
    #2 rst_ni = 1;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (pack_out(k) !== pack_exp(k)) begin
        errors++;
        $display("FAIL areset_post u%0d: got %h want %h", k, pack_out(k), pack_exp(k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rv32e();
    test_overflow();
    test_halt();
    test_saturation();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
